// File: rtl/yj_basic_cdc_hs_tx.sv
// Source-domain half of a two-phase (toggle) request/acknowledge CDC handshake.
// Optional one-entry skid register compiled in with `define YJ_CDC_HS_TX_SKID_EN.
module yj_basic_cdc_hs_tx #(
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          din_valid,
    input  logic [DW-1:0] din,
    output logic          din_ready,
    output logic          req_out,
    output logic [DW-1:0] dat_out,
    input  logic          ack_in,
    output logic          busy
);

    // state    | meaning
    // IDLE     | no word in flight; din accepted and launched at once
    // WAIT_ACK | word launched on dat_out, waiting for ack_s2 to match req_out
    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_ack_s1;
    logic          r_ack_s2;
    logic          r_req;
    logic [DW-1:0] r_dat;

    logic          w_done;
    logic          w_accept;
    logic          w_launch;
    logic [DW-1:0] w_launch_dat;
    logic          w_skid_load;
    logic          w_skid_clr;

`ifdef YJ_CDC_HS_TX_SKID_EN
    logic [DW-1:0] r_skid_dat;
    logic          r_skid_full;
`endif

    assign w_done   = (r_state == ST_WAIT_ACK) && (r_ack_s2 == r_req);
    assign w_accept = din_valid && din_ready;
    assign req_out  = r_req;
    assign dat_out  = r_dat;
    assign busy     = (r_state == ST_WAIT_ACK);

    always_comb begin
        w_state_nxt  = r_state;
        w_launch     = 1'b0;
        w_launch_dat = din;
        w_skid_load  = 1'b0;
        w_skid_clr   = 1'b0;
        din_ready    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    w_launch    = 1'b1;
                    w_state_nxt = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
`ifdef YJ_CDC_HS_TX_SKID_EN
                din_ready = !r_skid_full;
                if (w_done) begin
                    // Skid holds the older word, so it must go out before any new din.
                    if (r_skid_full) begin
                        w_launch     = 1'b1;
                        w_launch_dat = r_skid_dat;
                        w_skid_clr   = 1'b1;
                    end else if (w_accept) begin
                        w_launch = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_accept) begin
                    w_skid_load = 1'b1;
                end
`else
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                end
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_ack_s1 <= 1'b0;
            r_ack_s2 <= 1'b0;
            r_req    <= 1'b0;
            r_dat    <= '0;
        end else begin
            r_ack_s1 <= ack_in;
            r_ack_s2 <= r_ack_s1;
            r_state  <= w_state_nxt;
            if (w_launch) begin
                r_req <= ~r_req;
                r_dat <= w_launch_dat;
            end
        end
    end

`ifdef YJ_CDC_HS_TX_SKID_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_skid_dat  <= '0;
            r_skid_full <= 1'b0;
        end else if (w_skid_load) begin
            r_skid_dat  <= din;
            r_skid_full <= 1'b1;
        end else if (w_skid_clr) begin
            r_skid_full <= 1'b0;
        end
    end
`else
    logic w_unused;
    assign w_unused = w_accept ^ w_skid_load ^ w_skid_clr;
`endif

endmodule

// File: tb/tb_yj_basic_cdc_hs_tx.sv
// Bench for yj_basic_cdc_hs_tx: a transaction-level model (launch queue plus ack
// seen two edges late) checked every cycle, plus directed literal checks.
module tb_yj_basic_cdc_hs_tx;
    localparam int DW = 32;
`ifdef YJ_CDC_HS_TX_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic          din_valid;
    logic [DW-1:0] din;
    logic          din_ready;
    logic          req_out;
    logic [DW-1:0] dat_out;
    logic          ack_in;
    logic          busy;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    always #5 CLK = ~CLK;

    yj_basic_cdc_hs_tx #(.DW(DW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .din_valid (din_valid),
        .din       (din),
        .din_ready (din_ready),
        .req_out   (req_out),
        .dat_out   (dat_out),
        .ack_in    (ack_in),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one word in flight, a FIFO of accepted-but-unlaunched words (skid),
    // and the ack value as it becomes visible two edges after being sampled.
    bit            m_busy = 1'b0;
    bit            m_req  = 1'b0;
    logic [DW-1:0] m_dat  = '0;
    bit            m_ack_d1 = 1'b0;
    bit            m_ack_d2 = 1'b0;
    bit            m_done;
    bit            m_acc;
    logic [DW-1:0] m_q[$];

    function automatic bit m_ready();
        return !m_busy || (SKID && m_q.size() == 0);
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            m_busy = 1'b0; m_req = 1'b0; m_dat = '0;
            m_ack_d1 = 1'b0; m_ack_d2 = 1'b0;
            m_q.delete();
        end else begin
            m_done = m_busy && (m_ack_d2 == m_req);
            m_acc  = din_valid && m_ready();
            if (!m_busy) begin
                if (m_acc) begin m_req = !m_req; m_dat = din; m_busy = 1'b1; end
            end else if (m_done) begin
                if (m_q.size() != 0) begin m_req = !m_req; m_dat = m_q.pop_front(); end
                else if (m_acc) begin m_req = !m_req; m_dat = din; end
                else m_busy = 1'b0;
            end else if (m_acc) begin
                m_q.push_back(din);
            end
            m_ack_d2 = m_ack_d1;
            m_ack_d1 = ack_in;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("m_din_ready", din_ready, m_ready());
            check("m_busy", busy, m_busy);
            check("m_req_out", req_out, m_req);
            check("m_dat_out", dat_out, m_dat);
        end
    end

    task automatic send_word(input logic [DW-1:0] d);
        din_valid = 1'b1;
        din       = d;
        @(negedge CLK);
        din_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 20) begin
            @(negedge CLK);
            k++;
        end
        check(name, busy, 1'b0);
    endtask

    logic [DW-1:0] tbl_dat[4] = '{32'hDEAD_BEEF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678};
    int            tbl_dly[4] = '{0, 2, 5, 1};

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; ack_in = 1'b1; din_valid = 1'b0; din = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        chk_en = 1'b1;
        check("rst_req_out", req_out, 1'b0);
        check("rst_dat_out", dat_out, 32'h0);
        check("rst_din_ready", din_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        // ack_in=1 while idle with req_out=0: must not launch
        repeat (4) @(negedge CLK);
        check("idle_mismatch_req", req_out, 1'b0);
        check("idle_mismatch_busy", busy, 1'b0);
        ack_in = 1'b0;
        repeat (3) @(negedge CLK);

        send_word(32'hA5A5_0001);
        check("xfer_req_out", req_out, 1'b1);
        check("xfer_dat_out", dat_out, 32'hA5A5_0001);
        check("xfer_busy", busy, 1'b1);
`ifndef YJ_CDC_HS_TX_SKID_EN
        din_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 32'h5000_0000 + i;
            @(negedge CLK);
            check("bp_din_ready", din_ready, 1'b0);
            check("bp_dat_out", dat_out, 32'hA5A5_0001);
        end
        din_valid = 1'b0;
`endif
        ack_in = 1'b1;
        @(negedge CLK);
        check("lat_e0_busy", busy, 1'b1);
        @(negedge CLK);
        check("lat_e1_busy", busy, 1'b1);
        @(negedge CLK);
        check("lat_e2_busy", busy, 1'b0);
        check("lat_e2_din_ready", din_ready, 1'b1);

`ifdef YJ_CDC_HS_TX_SKID_EN
        send_word(32'h1);
        send_word(32'h2);
        check("skid_full_ready", din_ready, 1'b0);
        check("skid_hold_dat", dat_out, 32'h1);
        ack_in = 1'b0;
        repeat (3) @(negedge CLK);
        check("skid_launch_dat", dat_out, 32'h2);
        check("skid_launch_req", req_out, 1'b1);
        check("skid_launch_busy", busy, 1'b1);
        ack_in = 1'b1;
        wait_idle("skid_second_ack_idle");

        send_word(32'hAA);
        ack_in = 1'b0;
        repeat (2) @(negedge CLK);
        send_word(32'h3);
        check("simul_dat", dat_out, 32'h3);
        check("simul_req", req_out, 1'b1);
        check("simul_busy", busy, 1'b1);
        check("simul_skid_empty", din_ready, 1'b1);
        ack_in = 1'b1;
        wait_idle("simul_idle");
`endif

        send_word(32'h0BAD_0002);
        check("mid_busy", busy, 1'b1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("mid_rst_req", req_out, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", din_ready, 1'b1);
        check("mid_rst_dat", dat_out, 32'h0);
        ack_in = 1'b0;
        repeat (3) @(negedge CLK);
        send_word(32'hA5A5_0001);
        check("post_rst_req", req_out, 1'b1);
        check("post_rst_dat", dat_out, 32'hA5A5_0001);
        ack_in = 1'b1;
        wait_idle("post_rst_idle");

        for (int i = 0; i < 4; i++) begin
            send_word(tbl_dat[i]);
            check("tbl_dat", dat_out, tbl_dat[i]);
            repeat (tbl_dly[i]) @(negedge CLK);
            ack_in = ~ack_in;
            wait_idle("tbl_idle");
        end

        @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
